// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store unit: access-size
// encodings, FSM state encoding, and size/legality/split decode.
package lsu_pkg;

  // Access control encodings driven by the execute stage
  typedef enum logic [2:0] {
    LS_B  = 3'b000,
    LS_H  = 3'b001,
    LS_W  = 3'b010,
    LS_BU = 3'b100,
    LS_HU = 3'b101
  } ls_ctrl_e;

  // Master FSM states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE0  = 3'd1,
    ST_ISSUE1  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } lsu_state_e;

  // Access size in bytes (1, 2 or 4) from ctrl[1:0]
  function automatic logic [2:0] ls_size(input logic [2:0] ctrl);
    case (ctrl[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Encoding legality: unsigned variants are load-only, 011/11x are reserved
  function automatic logic ls_legal(input logic we, input logic [2:0] ctrl);
    logic ok;
    case (ctrl)
      LS_B, LS_H, LS_W: ok = 1'b1;
      LS_BU, LS_HU:     ok = !we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  // An access crosses a word boundary when offset + size exceeds 4
  function automatic logic ls_split(input logic [2:0] ctrl, input logic [1:0] off);
    return ({1'b0, off} + ls_size(ctrl)) > 3'd4;
  endfunction

endpackage

// File: rtl/lsu_master_if.sv
// Bundle of core-side request/response and memory-side beat signals for the
// load/store unit. The master modport is the LSU view; slave is the view of
// the core plus data memory surrounding it.
interface lsu_master_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_ctrl;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport master (
    input  req_valid, req_we, req_ctrl, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    output req_valid, req_we, req_ctrl, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane steering for the LSU: byte-enable mask over two words,
// store data shifted into lane position, and load data realigned and
// sign/zero extended from the {beat1, beat0} pair.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_ctrl,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata_lo,
  input  logic [31:0] i_rdata_hi,
  output logic [7:0]  o_mask,
  output logic [63:0] o_wdata,
  output logic [31:0] o_rdata
);
  logic [7:0]  w_mask_base;
  logic [4:0]  w_shamt;
  logic [31:0] w_rd_shift;

  assign w_shamt = {i_offset, 3'b000};

  // Unshifted enable pattern for the access size
  always_comb begin
    case (ls_size(i_ctrl))
      3'd1:    w_mask_base = 8'h01;
      3'd2:    w_mask_base = 8'h03;
      default: w_mask_base = 8'h0F;
    endcase
  end

  assign o_mask     = w_mask_base << i_offset;
  assign o_wdata    = {32'h0, i_wdata} << w_shamt;
  assign w_rd_shift = 32'({i_rdata_hi, i_rdata_lo} >> w_shamt);

  // Truncate the realigned word to the access size and extend
  always_comb begin
    case (ls_ctrl_e'(i_ctrl))
      LS_B:    o_rdata = {{24{w_rd_shift[7]}}, w_rd_shift[7:0]};
      LS_BU:   o_rdata = {24'h0, w_rd_shift[7:0]};
      LS_H:    o_rdata = {{16{w_rd_shift[15]}}, w_rd_shift[15:0]};
      LS_HU:   o_rdata = {16'h0, w_rd_shift[15:0]};
      default: o_rdata = w_rd_shift;
    endcase
  end
endmodule

// File: rtl/lsu_master.sv
// Load/store unit master: accepts one request per handshake, issues one or
// two word beats to a 1-cycle-latency memory, and returns a single-cycle
// response. Build option LSU_MISALIGNED_EN enables two-beat word-crossing
// accesses; without it such requests complete with an error and no traffic.
module lsu_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input logic          clk,
  input logic          rst_n,
  lsu_master_if.master bus
);
  lsu_state_e        r_state;
  lsu_state_e        w_state_next;
  logic              r_ready;
  logic              r_we;
  logic [2:0]        r_ctrl;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_rsp_err;
  logic [31:0]       r_rsp_rdata;

  logic              w_accept;
  logic              w_req_split;
  logic              w_req_ok;
  logic              w_issue;
  logic              w_beat1;
  logic [ADDR_W-1:0] w_word0;
  logic [ADDR_W-1:0] w_word1;
  logic [31:0]       w_ld_lo;
  logic [31:0]       w_ld_hi;
  logic [7:0]        w_mask;
  logic [63:0]       w_st_data;
  logic [31:0]       w_ld_ext;

  assign w_accept    = bus.req_valid && r_ready;
  assign w_req_split = ls_split(bus.req_ctrl, bus.req_addr[1:0]);

`ifdef LSU_MISALIGNED_EN
  logic        r_split;
  logic [31:0] r_beat0;

  assign w_req_ok = ls_legal(bus.req_we, bus.req_ctrl);
  assign w_issue  = (r_state == ST_ISSUE0) || (r_state == ST_ISSUE1);
  assign w_beat1  = (r_state == ST_ISSUE1);
  // Split loads hold beat 0 and take beat 1 live from the memory
  assign w_ld_lo  = r_split ? r_beat0 : bus.mem_rdata;
  assign w_ld_hi  = r_split ? bus.mem_rdata : 32'h0;
`else
  assign w_req_ok = ls_legal(bus.req_we, bus.req_ctrl) && !w_req_split;
  assign w_issue  = (r_state == ST_ISSUE0);
  assign w_beat1  = 1'b0;
  assign w_ld_lo  = bus.mem_rdata;
  assign w_ld_hi  = 32'h0;
`endif

  assign w_word0 = {r_addr[ADDR_W-1:2], 2'b00};
  assign w_word1 = w_word0 + ADDR_W'(4);

  lsu_align u_align (
    .i_ctrl     (r_ctrl),
    .i_offset   (r_addr[1:0]),
    .i_wdata    (r_wdata),
    .i_rdata_lo (w_ld_lo),
    .i_rdata_hi (w_ld_hi),
    .o_mask     (w_mask),
    .o_wdata    (w_st_data),
    .o_rdata    (w_ld_ext)
  );

  // Memory beat outputs are quiet (all zero) whenever no beat is issued
  assign bus.mem_req   = w_issue;
  assign bus.mem_we    = w_issue && r_we;
  assign bus.mem_addr  = !w_issue ? '0 : (w_beat1 ? w_word1 : w_word0);
  assign bus.mem_be    = !w_issue ? 4'h0 : (w_beat1 ? w_mask[7:4] : w_mask[3:0]);
  assign bus.mem_wdata = !(w_issue && r_we) ? 32'h0 :
                         (w_beat1 ? w_st_data[63:32] : w_st_data[31:0]);

  assign bus.req_ready = r_ready;
  assign bus.rsp_valid = (r_state == ST_DONE);
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rsp_rdata;

  // Next-state decode; illegal requests go straight to DONE
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_next = w_req_ok ? ST_ISSUE0 : ST_DONE;
      end
      ST_ISSUE0: begin
`ifdef LSU_MISALIGNED_EN
        if (r_split) w_state_next = ST_ISSUE1;
        else         w_state_next = r_we ? ST_DONE : ST_CAPTURE;
`else
        w_state_next = r_we ? ST_DONE : ST_CAPTURE;
`endif
      end
`ifdef LSU_MISALIGNED_EN
      ST_ISSUE1:  w_state_next = r_we ? ST_DONE : ST_CAPTURE;
`endif
      ST_CAPTURE: w_state_next = ST_DONE;
      ST_DONE:    w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // Latch the request fields on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_ctrl  <= 3'b000;
      r_addr  <= '0;
      r_wdata <= 32'h0;
    end else if (w_accept) begin
      r_we    <= bus.req_we;
      r_ctrl  <= bus.req_ctrl;
      r_addr  <= bus.req_addr;
      r_wdata <= bus.req_wdata;
    end
  end

  // Ready follows IDLE one cycle late so it stays low through reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready     <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'h0;
    end else begin
      r_ready     <= (w_state_next == ST_IDLE);
      r_rsp_err   <= (r_state == ST_IDLE) && (w_state_next == ST_DONE);
      r_rsp_rdata <= (r_state == ST_CAPTURE) ? w_ld_ext : 32'h0;
    end
  end

`ifdef LSU_MISALIGNED_EN
  // Remember split-ness and hold beat-0 read data across the second beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_split <= 1'b0;
      r_beat0 <= 32'h0;
    end else begin
      if (w_accept) r_split <= w_req_split;
      if (r_state == ST_ISSUE1) r_beat0 <= bus.mem_rdata;
    end
  end
`endif

endmodule

// File: doc/lsu_master.md
# lsu_master

Load/store unit on the initiator side of the core's data-memory port. It accepts one load or store per handshake from the execute stage and drives a word-addressed, byte-enabled memory with 1-cycle read latency. It aligns and byte-lanes store data, sign- or zero-extends load data, and splits misaligned accesses into two word beats. It sits between the core pipeline and the 1 KB data memory.

## Interface
- ADDR_W, 32, byte-address width of `req_addr`/`mem_addr`.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  LSU can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_ctrl  in  3  encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, LSB-aligned.
- rsp_valid  out  1  one-cycle pulse: access complete.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  qualified by rsp_valid: illegal request.
- mem_req  out  1  memory beat strobe.
- mem_we  out  1  beat is a write.
- mem_addr  out  ADDR_W  word-aligned beat address (bits [1:0] = 0).
- mem_be  out  4  byte enables; bit i = byte lane i.
- mem_wdata  out  32  lane-positioned write data.
- mem_rdata  in  32  read data, valid in the cycle after a read beat.

## Operation
- States: IDLE, ISSUE0, ISSUE1, CAPTURE, DONE.
- Accept on `req_valid && req_ready`. Latch we, ctrl, addr and wdata.
- Size: 1/2/4 bytes from ctrl[1:0]. Offset is `addr[1:0]`. A request is split when offset + size > 4.
- Illegal requests: ctrl 011, 110 or 111; stores with ctrl[2] = 1; split requests when LSU_MISALIGNED_EN is undefined.
  - Path: IDLE → DONE with rsp_err = 1.
  - No mem_req is issued.
- Beat 0 has the word address of addr. Beat 1 has beat-0 address + 4, wrapping modulo 2^ADDR_W.
- Byte enables: 8-bit mask = ((1<<size)-1) << offset. Beat 0 gets mask[3:0]; beat 1 gets mask[7:4].
- Store data: 64-bit value = wdata << (8*offset). Beat 0 gets bits [31:0]; beat 1 gets bits [63:32].
- Load data: {beat1, beat0} >> (8*offset), then truncate to size and extend.
  - B and H are sign-extended; BU and HU are zero-extended.
  - For an unsplit access, beat1 = 0.
- Transitions:
  - IDLE → ISSUE0 on a legal accept.
  - ISSUE0 → ISSUE1 if split, else CAPTURE (load) or DONE (store).
  - ISSUE1 → CAPTURE (load) or DONE (store).
  - CAPTURE → DONE.
  - DONE → IDLE.
- `mem_req` is high only in ISSUE0 and ISSUE1. When `mem_req` is low, mem_we, mem_be and mem_wdata are 0.

## Timing
- Accept in cycle N. Cycle of the rsp_valid pulse:
  - aligned store: N+2
  - split store: N+3
  - aligned load: N+3
  - split load: N+4
  - error: N+1
- Beat-0 read data is captured in the cycle after ISSUE0, whether the next state is ISSUE1 or CAPTURE. Beat-1 data is captured in CAPTURE.
- rsp_rdata and rsp_err are registered and valid only during the rsp_valid pulse. Both read 0 otherwise.
- Back-to-back: req_ready rises the cycle after DONE, so the earliest next accept is at rsp_valid + 1.
- Reset values (all while rst_n = 0): state IDLE; req_ready 0; rsp_valid 0; rsp_err 0; rsp_rdata 0; mem_req 0; mem_we 0; mem_addr 0; mem_be 0; mem_wdata 0.
- Reset mid-operation: the in-flight access is abandoned and no rsp_valid is produced. A beat already written is not rolled back.

## Configuration
- LSU_MISALIGNED_EN defined: split accesses are performed in two beats as above.
- LSU_MISALIGNED_EN undefined:
  - ISSUE1 is not compiled.
  - A split request completes with rsp_err = 1 at N+1 and no memory traffic.
  - Aligned behaviour is identical in both builds.

## Structure
- Package lsu_pkg holds:
  - ctrl encodings as an enum (LS_B, LS_H, LS_W, LS_BU, LS_HU);
  - the FSM state enum;
  - functions for size decode and legality.
- Sub-module lsu_align is purely combinational. It produces mask, shifted store data and extended load data from ctrl, offset and data.
- The FSM and registers live in lsu_master.

## Test plan
- Aligned SW: addr 0x10, data 0xDEADBEEF → one beat at N+1: addr 0x10, be 1111, wdata 0xDEADBEEF. rsp_valid at N+2 with rsp_err 0.
- SB at 0x13, data 0x000000A5 → be 1000, wdata 0xA5000000. A following LB at 0x13 returns 0xFFFFFFA5; LBU at 0x13 returns 0x000000A5.
- Split SW (build with LSU_MISALIGNED_EN): addr 0x21, data 0x11223344.
  - Beats: 0x20 with be 1110 and wdata 0x22334400; 0x24 with be 0001 and wdata 0x00000011.
  - LW at 0x21 returns 0x11223344 at N+4.
- Same split SW in a build without LSU_MISALIGNED_EN → rsp_err 1 at N+1, mem_req never asserted.
- LHU at 0x2 reading word 0x8001xxxx → 0x00008001. LH on the same word → 0xFFFF8001. ctrl 011 → rsp_err 1.
- rst_n asserted in ISSUE1 of a split store → all outputs 0 immediately. After release req_ready = 1 and no rsp_valid is produced. Word address 0xFFFFFFFC + 4 wraps to 0x0.
